// File: rtl/fetch_sequencer.sv
// fetch_sequencer: issues one I$ fetch at a time, forwards each response to the
// instruction queue and picks the next fetch address.
// Address priority: flush > replay > branch-predict redirect > sequential.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   flush_i, flush_addr_i         backend redirect and its target
//   icache_req_o, icache_vaddr_o  fetch request and address (held until accepted)
//   icache_ready_i                I$ accepts the request this cycle
//   icache_kill_o                 kill the in-flight request (1-cycle pulse)
//   icache_valid_i                I$ response valid
//   pkt_valid_o, pkt_addr_o       packet forwarded to the instruction queue
//   iq_ready_i                    instruction queue can take a packet
//   replay_i, replay_addr_i       queue overflow on the forwarded packet
//   bp_taken_i, bp_addr_i         predicted-taken CF in the forwarded packet
module fetch_sequencer #(
  parameter int unsigned          FETCH_BYTES = 4,
  parameter int unsigned          VADDR_W     = 64,
  parameter logic [VADDR_W-1:0]   BOOT_ADDR   = VADDR_W'(64'h8000_0000)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic [VADDR_W-1:0] flush_addr_i,
  output logic               icache_req_o,
  output logic [VADDR_W-1:0] icache_vaddr_o,
  input  logic               icache_ready_i,
  output logic               icache_kill_o,
  input  logic               icache_valid_i,
  output logic               pkt_valid_o,
  output logic [VADDR_W-1:0] pkt_addr_o,
  input  logic               iq_ready_i,
  input  logic               replay_i,
  input  logic [VADDR_W-1:0] replay_addr_i,
  input  logic               bp_taken_i,
  input  logic [VADDR_W-1:0] bp_addr_i
);

  localparam int unsigned OFF_W = $clog2(FETCH_BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    STALL = 2'd3
  } state_e;

  state_e             state_q;
  logic [VADDR_W-1:0] fetch_addr_q;
  logic               req_q;

  logic [VADDR_W-1:0] seq_addr;
  logic [VADDR_W-1:0] next_addr;
  logic               fwd;

  // Sequential successor: align down to the packet boundary, then step one packet.
  always_comb begin
    seq_addr = {fetch_addr_q[VADDR_W-1:OFF_W], OFF_W'(0)} + VADDR_W'(FETCH_BYTES);
  end

  // Redirect selection for a forward cycle; replay beats the prediction because
  // the predicted CF may not have been pushed.
  always_comb begin
    next_addr = seq_addr;
    if (replay_i) begin
      next_addr = replay_addr_i;
    end else if (bp_taken_i) begin
      next_addr = bp_addr_i;
    end
  end

  // A response is forwarded only in WAIT with queue space and no flush.
  always_comb begin
    fwd = (state_q == WAIT) && icache_valid_i && iq_ready_i && !flush_i;
  end

  assign pkt_valid_o    = fwd;
  assign pkt_addr_o     = fetch_addr_q;
  assign icache_req_o   = req_q;
  assign icache_vaddr_o = fetch_addr_q;
  // Kill only matters while a request is presented or outstanding.
  assign icache_kill_o  = flush_i && ((state_q == REQ) || (state_q == WAIT));

  // Fetch FSM; req_q mirrors the REQ state so the request output is a flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      fetch_addr_q <= BOOT_ADDR;
      req_q        <= 1'b0;
    end else if (flush_i) begin
      // Flush overrides everything, including a same-cycle acceptance.
      state_q      <= REQ;
      fetch_addr_q <= flush_addr_i;
      req_q        <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_q <= REQ;
          req_q   <= 1'b1;
        end
        REQ: begin
          if (icache_ready_i) begin
            state_q <= WAIT;
            req_q   <= 1'b0;
          end
        end
        WAIT: begin
          if (icache_valid_i) begin
            if (iq_ready_i) begin
              state_q      <= REQ;
              fetch_addr_q <= next_addr;
              req_q        <= 1'b1;
            end else begin
              // Data stays in the I$; we re-request the same address later.
              state_q <= STALL;
            end
          end
        end
        STALL: begin
          if (iq_ready_i) begin
            state_q <= REQ;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule
